// File: rtl/sdram_arbiter_pkg.sv
// Shared arbiter encodings: FSM states, SDRAM op codes and idle bus values.
// Used by sdram_arbiter and its optional watchdog (SDRAM_ARB_TIMEOUT_EN).
package sdram_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_ARBIT = 3'd1,
        ST_AREF  = 3'd2,
        ST_WRITE = 3'd3,
        ST_READ  = 3'd4
    } arb_state_e;

    // {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] OP_NOP   = 4'b0111;
    localparam logic [3:0] OP_PRE   = 4'b0010;
    localparam logic [3:0] OP_AREF  = 4'b0001;
    localparam logic [3:0] OP_MREG  = 4'b0000;
    localparam logic [3:0] OP_ACT   = 4'b0011;
    localparam logic [3:0] OP_WRITE = 4'b0100;
    localparam logic [3:0] OP_READ  = 4'b0101;

    localparam logic [1:0]  BA_IDLE   = 2'b11;
    localparam logic [12:0] ADDR_IDLE = 13'h1fff;

    typedef struct packed {
        logic [3:0]  cmd;
        logic [1:0]  ba;
        logic [12:0] addr;
    } sdram_bus_t;

    localparam sdram_bus_t BUS_NOP = '{cmd: OP_NOP, ba: BA_IDLE, addr: ADDR_IDLE};

endpackage

// File: rtl/sdram_arb_watchdog.sv
// Grant watchdog: counts cycles while a grant is open, flags expiry.
// Only instantiated when SDRAM_ARB_TIMEOUT_EN is defined.
module sdram_arb_watchdog #(
    parameter int TIMEOUT_CLKS = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run_i,
    output logic expire_o
);

    logic [15:0] cnt_q, cnt_d;

    // Not running means ARBIT/INIT, which always precedes a grant,
    // so the count is already zero on grant entry.
    always_comb begin
        cnt_d = '0;
        if (run_i) cnt_d = cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign expire_o = run_i && (cnt_q == 16'(TIMEOUT_CLKS - 1));

endmodule

// File: rtl/sdram_arbiter.sv
// SDRAM command-bus arbiter: init hold-off, then refresh > write > read.
// Optional grant watchdog enabled by `define SDRAM_ARB_TIMEOUT_EN.
module sdram_arbiter
    import sdram_arbiter_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int TIMEOUT_CLKS = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        init_cmd,
    input  logic [1:0]        init_ba,
    input  logic [12:0]       init_addr,
    input  logic              init_end,
    input  logic              aref_req,
    output logic              aref_en,
    input  logic              aref_end,
    input  logic [3:0]        aref_cmd,
    input  logic [1:0]        aref_ba,
    input  logic [12:0]       aref_addr,
    input  logic              wr_req,
    output logic              wr_en,
    input  logic              wr_end,
    input  logic [3:0]        wr_cmd,
    input  logic [1:0]        wr_ba,
    input  logic [12:0]       wr_addr,
    input  logic [DATA_W-1:0] wr_sdram_data,
    input  logic              wr_sdram_en,
    input  logic              rd_req,
    output logic              rd_en,
    input  logic              rd_end,
    input  logic [3:0]        rd_cmd,
    input  logic [1:0]        rd_ba,
    input  logic [12:0]       rd_addr,
    output logic              sdram_cke,
    output logic              sdram_cs_n,
    output logic              sdram_ras_n,
    output logic              sdram_cas_n,
    output logic              sdram_we_n,
    output logic [1:0]        sdram_ba,
    output logic [12:0]       sdram_addr,
    output logic [DATA_W-1:0] sdram_dq_out,
    output logic              sdram_dq_oe,
    output logic              err_timeout
);

    arb_state_e state_q, state_d;
    logic       aref_en_q, aref_en_d;
    logic       wr_en_q, wr_en_d;
    logic       rd_en_q, rd_en_d;
    logic       busy, chan_end, expire;
    sdram_bus_t bus;

    assign busy = (state_q == ST_AREF) || (state_q == ST_WRITE) ||
                  (state_q == ST_READ);

`ifdef SDRAM_ARB_TIMEOUT_EN
    logic err_q;

    sdram_arb_watchdog #(
        .TIMEOUT_CLKS(TIMEOUT_CLKS)
    ) u_wdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .run_i   (busy),
        .expire_o(expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_q <= 1'b0;
        else        err_q <= expire && !chan_end;
    end

    assign err_timeout = err_q;
`else
    logic [15:0] unused_timeout;
    assign unused_timeout = 16'(TIMEOUT_CLKS);
    assign expire         = 1'b0;
    assign err_timeout    = 1'b0;
`endif

    always_comb begin
        chan_end = 1'b0;
        unique case (state_q)
            ST_AREF:  chan_end = aref_end;
            ST_WRITE: chan_end = wr_end;
            ST_READ:  chan_end = rd_end;
            default:  chan_end = 1'b0;
        endcase
    end

    // Grant pulses are registered with the state, so each lasts one cycle.
    always_comb begin
        state_d   = state_q;
        aref_en_d = 1'b0;
        wr_en_d   = 1'b0;
        rd_en_d   = 1'b0;
        unique case (state_q)
            ST_INIT: if (init_end) state_d = ST_ARBIT;
            ST_ARBIT: begin
                if (aref_req) begin
                    state_d   = ST_AREF;
                    aref_en_d = 1'b1;
                end else if (wr_req) begin
                    state_d = ST_WRITE;
                    wr_en_d = 1'b1;
                end else if (rd_req) begin
                    state_d = ST_READ;
                    rd_en_d = 1'b1;
                end
            end
            ST_AREF, ST_WRITE, ST_READ:
                if (chan_end || expire) state_d = ST_ARBIT;
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_INIT;
            aref_en_q <= 1'b0;
            wr_en_q   <= 1'b0;
            rd_en_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            aref_en_q <= aref_en_d;
            wr_en_q   <= wr_en_d;
            rd_en_q   <= rd_en_d;
        end
    end

    always_comb begin
        bus = BUS_NOP;
        unique case (state_q)
            ST_INIT:  bus = '{cmd: init_cmd, ba: init_ba, addr: init_addr};
            ST_AREF:  bus = '{cmd: aref_cmd, ba: aref_ba, addr: aref_addr};
            ST_WRITE: bus = '{cmd: wr_cmd, ba: wr_ba, addr: wr_addr};
            ST_READ:  bus = '{cmd: rd_cmd, ba: rd_ba, addr: rd_addr};
            default:  bus = BUS_NOP;
        endcase
    end

    assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = bus.cmd;
    assign sdram_ba     = bus.ba;
    assign sdram_addr   = bus.addr;
    assign sdram_cke    = 1'b1;
    assign sdram_dq_oe  = (state_q == ST_WRITE) && wr_sdram_en;
    assign sdram_dq_out = (state_q == ST_WRITE) ? wr_sdram_data : '0;
    assign aref_en      = aref_en_q;
    assign wr_en        = wr_en_q;
    assign rd_en        = rd_en_q;

endmodule
